// File: rtl/processor_pkg.sv
// rtl/processor_pkg.sv - RV32I subset encodings, ALU/immediate/write-back selectors and helpers
package processor_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_t;

    typedef enum logic [2:0] {WB_ALU, WB_MEM, WB_PC4, WB_IMM, WB_PCIMM} wb_sel_t;

    function automatic logic [31:0] gen_imm(input logic [31:0] inst, input imm_t kind);
        case (kind)
            IMM_S:   gen_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   gen_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   gen_imm = {inst[31:12], 12'b0};
            IMM_J:   gen_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: gen_imm = {{20{inst[31]}}, inst[31:20]};
        endcase
    endfunction

    function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_SUB:  alu = a - b;
            ALU_SLL:  alu = a << b[4:0];
            ALU_SLT:  alu = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: alu = {31'b0, a < b};
            ALU_XOR:  alu = a ^ b;
            ALU_SRL:  alu = a >> b[4:0];
            ALU_SRA:  alu = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:   alu = a | b;
            ALU_AND:  alu = a & b;
            default:  alu = a + b;
        endcase
    endfunction

endpackage

// File: rtl/processor_data_mem.sv
// rtl/processor_data_mem.sv - word-addressed data RAM, async read, sync write, low bits dropped
module data_mem #(
    parameter int DMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    localparam int AW = $clog2(DMEM_WORDS);

    logic [31:0] mem [0:DMEM_WORDS-1];
    logic        unused_bits;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr[AW+1:2]] <= wdata;
        end
    end

    assign rdata       = mem[addr[AW+1:2]];
    assign unused_bits = ^{addr[31:AW+2], addr[1:0]};

endmodule

// File: rtl/processor_inst_mem.sv
// rtl/processor_inst_mem.sv - combinational instruction ROM, preloaded hierarchically
module inst_mem #(
    parameter int IMEM_WORDS = 1024
) (
    input  logic [31:0] addr,
    output logic [31:0] inst
);
    localparam int AW = $clog2(IMEM_WORDS);

    logic [31:0] mem [0:IMEM_WORDS-1];
    logic        unused_bits;

    assign inst        = mem[addr[AW+1:2]];
    assign unused_bits = ^{addr[31:AW+2], addr[1:0]};

endmodule

// File: rtl/processor_reg_file.sv
// rtl/processor_reg_file.sv - 32x32 register file, two async reads, one sync write, x0 hardwired
module reg_file (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data
);
    logic [31:0] reg_mem [0:31];

    // No reset: preloaded contents must survive rst.
    always_ff @(posedge clk) begin
        if (we && rd_addr != 5'd0) begin
            reg_mem[rd_addr] <= rd_data;
        end
    end

    assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : reg_mem[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : reg_mem[rs2_addr];

endmodule

// File: rtl/processor.sv
// rtl/processor.sv - single-cycle RV32I subset core with private instruction/data memories
module processor
    import processor_pkg::*;
#(
    parameter int IMEM_WORDS = 1024,
    parameter int DMEM_WORDS = 1024
) (
    input logic clk,
    input logic rst
);
    logic [31:0] pc_out;
    logic [31:0] inst, imm, rs1_data, rs2_data, alu_b, alu_res, load_data;
    logic [31:0] wb_data, pc_plus4, next_pc;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;

    alu_op_t     alu_op;
    imm_t        imm_type;
    wb_sel_t     wb_sel;
    logic        reg_we, mem_we, alu_src_imm, is_branch, is_jal, is_jalr, taken;

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign funct7 = inst[31:25];

    inst_mem #(.IMEM_WORDS(IMEM_WORDS)) inst_mem_i (
        .addr (pc_out),
        .inst (inst)
    );

    // Unrecognised encodings leave every enable low and fall through to PC+4.
    always_comb begin
        alu_op      = ALU_ADD;
        imm_type    = IMM_I;
        wb_sel      = WB_ALU;
        reg_we      = 1'b0;
        mem_we      = 1'b0;
        alu_src_imm = 1'b0;
        is_branch   = 1'b0;
        is_jal      = 1'b0;
        is_jalr     = 1'b0;
        case (opcode)
            OP_REG: begin
                if (funct7 == F7_BASE ||
                    (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR))) begin
                    reg_we = 1'b1;
                    case (funct3)
                        F3_ADD:  alu_op = (funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                        F3_SLL:  alu_op = ALU_SLL;
                        F3_SLT:  alu_op = ALU_SLT;
                        F3_SLTU: alu_op = ALU_SLTU;
                        F3_XOR:  alu_op = ALU_XOR;
                        F3_SR:   alu_op = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        F3_OR:   alu_op = ALU_OR;
                        default: alu_op = ALU_AND;
                    endcase
                end
            end
            OP_IMM: begin
                alu_src_imm = 1'b1;
                case (funct3)
                    F3_ADD:  begin reg_we = 1'b1; alu_op = ALU_ADD;  end
                    F3_SLT:  begin reg_we = 1'b1; alu_op = ALU_SLT;  end
                    F3_SLTU: begin reg_we = 1'b1; alu_op = ALU_SLTU; end
                    F3_XOR:  begin reg_we = 1'b1; alu_op = ALU_XOR;  end
                    F3_OR:   begin reg_we = 1'b1; alu_op = ALU_OR;   end
                    F3_AND:  begin reg_we = 1'b1; alu_op = ALU_AND;  end
                    F3_SLL: begin
                        reg_we = (funct7 == F7_BASE);
                        alu_op = ALU_SLL;
                    end
                    default: begin
                        reg_we = (funct7 == F7_BASE || funct7 == F7_ALT);
                        alu_op = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    end
                endcase
            end
            OP_LOAD: begin
                alu_src_imm = 1'b1;
                wb_sel      = WB_MEM;
                reg_we      = (funct3 == F3_WORD);
            end
            OP_STORE: begin
                alu_src_imm = 1'b1;
                imm_type    = IMM_S;
                mem_we      = (funct3 == F3_WORD);
            end
            OP_BRANCH: begin
                imm_type  = IMM_B;
                is_branch = (funct3 != 3'b010 && funct3 != 3'b011);
            end
            OP_JAL: begin
                imm_type = IMM_J;
                wb_sel   = WB_PC4;
                reg_we   = 1'b1;
                is_jal   = 1'b1;
            end
            OP_JALR: begin
                alu_src_imm = 1'b1;
                wb_sel      = WB_PC4;
                reg_we      = (funct3 == F3_JALR);
                is_jalr     = (funct3 == F3_JALR);
            end
            OP_LUI: begin
                imm_type = IMM_U;
                wb_sel   = WB_IMM;
                reg_we   = 1'b1;
            end
            OP_AUIPC: begin
                imm_type = IMM_U;
                wb_sel   = WB_PCIMM;
                reg_we   = 1'b1;
            end
            default: ;
        endcase
    end

    assign imm     = gen_imm(inst, imm_type);
    assign alu_b   = alu_src_imm ? imm : rs2_data;
    assign alu_res = alu(alu_op, rs1_data, alu_b);

    always_comb begin
        case (funct3)
            F3_BEQ:  taken = (rs1_data == rs2_data);
            F3_BNE:  taken = (rs1_data != rs2_data);
            F3_BLT:  taken = ($signed(rs1_data) < $signed(rs2_data));
            F3_BGE:  taken = ($signed(rs1_data) >= $signed(rs2_data));
            F3_BLTU: taken = (rs1_data < rs2_data);
            F3_BGEU: taken = (rs1_data >= rs2_data);
            default: taken = 1'b0;
        endcase
    end

    assign pc_plus4 = pc_out + 32'd4;

    always_comb begin
        if (is_jalr)                 next_pc = alu_res & ~32'd1;
        else if (is_jal)             next_pc = pc_out + imm;
        else if (is_branch && taken) next_pc = pc_out + imm;
        else                         next_pc = pc_plus4;
    end

    always_comb begin
        case (wb_sel)
            WB_MEM:   wb_data = load_data;
            WB_PC4:   wb_data = pc_plus4;
            WB_IMM:   wb_data = imm;
            WB_PCIMM: wb_data = pc_out + imm;
            default:  wb_data = alu_res;
        endcase
    end

    reg_file reg_file_i (
        .clk      (clk),
        .we       (reg_we && !rst),
        .rs1_addr (rs1),
        .rs2_addr (rs2),
        .rd_addr  (rd),
        .rd_data  (wb_data),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data)
    );

    data_mem #(.DMEM_WORDS(DMEM_WORDS)) data_mem_i (
        .clk   (clk),
        .we    (mem_we && !rst),
        .addr  (alu_res),
        .wdata (rs2_data),
        .rdata (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_out <= 32'd0;
        else     pc_out <= next_pc;
    end

endmodule

// File: tb/tb_processor.sv
// tb/tb_processor.sv - directed self-checking bench for the single-cycle processor
module tb_processor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    processor #(.IMEM_WORDS(1024), .DMEM_WORDS(1024)) dut (
        .clk (clk),
        .rst (rst)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Hold reset and refill instruction memory with NOPs before each program.
    task automatic restart();
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 1024; i++) dut.inst_mem_i.mem[i] = 32'h0000_0013;
    endtask

    initial begin
        // add x3,x4,x2 then reset behaviour
        restart();
        check("reset_pc", dut.pc_out, 32'h0);
        dut.reg_file_i.reg_mem[0] = 32'h0;
        dut.reg_file_i.reg_mem[2] = 32'd5;
        dut.reg_file_i.reg_mem[4] = 32'd7;
        dut.reg_file_i.reg_mem[3] = 32'h0;
        dut.inst_mem_i.mem[0] = 32'h0022_01B3;
        step();
        check("held_in_reset_pc", dut.pc_out, 32'h0);
        check("no_write_in_reset", dut.reg_file_i.reg_mem[3], 32'h0);
        rst = 1'b0;
        step();
        check("add_x3", dut.reg_file_i.reg_mem[3], 32'd12);
        check("pc_after_1", dut.pc_out, 32'd4);
        step();
        check("pc_after_2", dut.pc_out, 32'd8);
        step();
        check("pc_after_3", dut.pc_out, 32'd12);
        #2 rst = 1'b1;
        #1;
        check("async_reset_pc", dut.pc_out, 32'h0);
        check("reset_keeps_x3", dut.reg_file_i.reg_mem[3], 32'd12);
        check("reset_keeps_x2", dut.reg_file_i.reg_mem[2], 32'd5);

        // x0 is never written
        restart();
        dut.reg_file_i.reg_mem[1] = 32'h55;
        dut.inst_mem_i.mem[0] = 32'h0050_0013;
        dut.inst_mem_i.mem[1] = 32'h0000_00B3;
        rst = 1'b0;
        step();
        step();
        check("x0_stays_zero", dut.reg_file_i.reg_mem[0], 32'h0);
        check("add_x1_from_x0", dut.reg_file_i.reg_mem[1], 32'h0);

        // store then load
        restart();
        dut.reg_file_i.reg_mem[1] = 32'h100;
        dut.reg_file_i.reg_mem[2] = 32'hDEAD_BEEF;
        dut.reg_file_i.reg_mem[3] = 32'h0;
        dut.inst_mem_i.mem[0] = 32'h0020_A023;
        dut.inst_mem_i.mem[1] = 32'h0000_A183;
        rst = 1'b0;
        step();
        check("sw_dmem", dut.data_mem_i.mem[64], 32'hDEAD_BEEF);
        step();
        check("lw_x3", dut.reg_file_i.reg_mem[3], 32'hDEAD_BEEF);

        // branches and jal
        restart();
        dut.reg_file_i.reg_mem[1] = 32'h0;
        dut.inst_mem_i.mem[0] = 32'h0000_0463;
        dut.inst_mem_i.mem[2] = 32'h0100_00EF;
        dut.inst_mem_i.mem[6] = 32'h0000_1463;
        rst = 1'b0;
        step();
        check("beq_taken_pc", dut.pc_out, 32'd8);
        step();
        check("jal_link", dut.reg_file_i.reg_mem[1], 32'd12);
        check("jal_pc", dut.pc_out, 32'd24);
        step();
        check("bne_not_taken_pc", dut.pc_out, 32'd28);

        // shifts and compares on a sign-bit operand
        restart();
        dut.reg_file_i.reg_mem[1] = 32'h8000_0000;
        dut.inst_mem_i.mem[0] = 32'h4040_D113;
        dut.inst_mem_i.mem[1] = 32'h0040_D193;
        dut.inst_mem_i.mem[2] = 32'h0000_A233;
        dut.inst_mem_i.mem[3] = 32'h0000_B2B3;
        rst = 1'b0;
        repeat (4) step();
        check("srai", dut.reg_file_i.reg_mem[2], 32'hF800_0000);
        check("srli", dut.reg_file_i.reg_mem[3], 32'h0800_0000);
        check("slt", dut.reg_file_i.reg_mem[4], 32'd1);
        check("sltu", dut.reg_file_i.reg_mem[5], 32'd0);

        // lui, auipc, jalr, unsupported opcode, sub
        restart();
        dut.reg_file_i.reg_mem[9]  = 32'h40;
        dut.reg_file_i.reg_mem[31] = 32'hA5;
        dut.inst_mem_i.mem[0]  = 32'h1234_5337;
        dut.inst_mem_i.mem[1]  = 32'h0000_1397;
        dut.inst_mem_i.mem[2]  = 32'h0054_8467;
        dut.inst_mem_i.mem[17] = 32'hFFFF_FFFF;
        dut.inst_mem_i.mem[18] = 32'h4060_0533;
        rst = 1'b0;
        step();
        check("lui", dut.reg_file_i.reg_mem[6], 32'h1234_5000);
        step();
        check("auipc", dut.reg_file_i.reg_mem[7], 32'h0000_1004);
        step();
        check("jalr_link", dut.reg_file_i.reg_mem[8], 32'd12);
        check("jalr_pc", dut.pc_out, 32'h44);
        step();
        check("nop_pc", dut.pc_out, 32'h48);
        check("nop_no_write", dut.reg_file_i.reg_mem[31], 32'hA5);
        step();
        check("sub", dut.reg_file_i.reg_mem[10], 32'hEDCB_B000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
